pipeline_register: RTL and testbench

PIPELINE_REGISTER -- requirements
Module: pipeline_register

---
 rtl/pipeline_register.sv | 146 ++++++++++++++
 tb/tb_pipeline_register.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_register.sv
// pipeline_register
//
// Purpose
//   A DEPTH-stage valid/ready register pipeline with bubble collapsing.
//   Stage 0 is on the input side and stage DEPTH-1 drives the output. Each
//   stage has a data register d[i] and a valid flag v[i]. A stage advances
//   when it is empty or when the stage after it advances. Ready therefore
//   propagates combinationally from out_ready back to in_ready, so a full
//   pipeline with out_ready=1 still accepts one word per cycle.
//
// Handshake
//   A word moves across a boundary on a rising Clk edge where valid and
//   ready on that boundary are both 1. A producer holds valid (and its
//   data) stable until that edge. The ready signals here never depend on
//   the valid signal of the same boundary.
//
// Parameters
//   DATAWIDTH : data path width in bits (>= 1)
//   DEPTH     : number of register stages (>= 1)
//
// Ports
//   Clk       : clock; all state changes on the rising edge
//   Rst_n     : asynchronous active-low reset; clears every v[i] and d[i]
//   Flush     : synchronous clear of every v[i]; d[i] keeps its value
//   in_valid  : upstream word present
//   in_data   : upstream word
//   in_ready  : word on in_data is taken this cycle (combinational)
//   out_valid : v[DEPTH-1], taken directly from a register
//   out_data  : d[DEPTH-1], taken directly from a register
//   out_ready : downstream takes out_data this cycle
//   occupancy : number of valid stages (only with PIPELINE_REGISTER_OCC_EN)
//
// Configuration
//   PIPELINE_REGISTER_OCC_EN : when defined, adds the occupancy port and
//   its registered counter. When undefined, the port and counter are absent.

module pipeline_register #(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 2
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Flush,
  input  logic                 in_valid,
  input  logic [DATAWIDTH-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [DATAWIDTH-1:0] out_data,
  input  logic                 out_ready
`ifdef PIPELINE_REGISTER_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  logic [DATAWIDTH-1:0] d    [DEPTH];
  logic [DATAWIDTH-1:0] d_in [DEPTH];
  logic [DEPTH-1:0]     v;
  logic [DEPTH-1:0]     v_in;
  logic [DEPTH-1:0]     en;

  // Advance enables, computed from the output side back to the input side.
  // The running term is kept in a local variable so en never reads itself.
  always_comb begin : en_chain
    logic carry;
    en    = '0;
    carry = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      carry = !v[i] | carry;
      en[i] = carry;
    end
  end

  // The word offered to each stage: in_data/in_valid for stage 0, and the
  // previous stage's registers for every later stage.
  always_comb begin
    v_in[0] = in_valid;
    d_in[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      v_in[i] = v[i-1];
      d_in[i] = d[i-1];
    end
  end

  assign in_ready  = en[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  // Valid flags. Flush has priority over every advance, and an input word
  // offered during Flush is dropped with the rest.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      v <= '0;
    end else if (Flush) begin
      v <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (en[i]) begin
          v[i] <= v_in[i];
        end
      end
    end
  end

  // Data registers. They load only when a valid word actually moves in, so
  // a bubble moving through a stage leaves that stage's stale data alone.
  // Flush leaves the data unchanged.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
      end
    end else if (!Flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (en[i] && v_in[i]) begin
          d[i] <= d_in[i];
        end
      end
    end
  end

`ifdef PIPELINE_REGISTER_OCC_EN
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & en[0];
  assign out_fire = v[DEPTH-1] & out_ready;

  // Transfers only enter at stage 0 and leave at stage DEPTH-1. The count
  // therefore tracks the number of set valid flags without a popcount.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      occupancy <= '0;
    end else if (Flush) begin
      occupancy <= '0;
    end else if (in_fire && !out_fire) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (out_fire && !in_fire) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_register.sv
// tb_pipeline_register
//
// Self-checking bench for pipeline_register with DATAWIDTH=8 and DEPTH=3.
// The reference model is the ordered list of words that have been accepted
// and not yet emitted or discarded. The driver appends a word when its input
// transfer happens. The monitor pops the list on every output transfer and
// checks the data and the accept-to-emit latency. Every cycle it also checks:
//   - in_ready against "not (count == DEPTH and out_ready == 0)";
//   - occupancy against the list size, when the occupancy port is built in.
// Inputs change 1 time unit after the rising edge. Signals are sampled on
// the falling edge.

module tb_pipeline_register;

  localparam int DW    = 8;
  localparam int DEPTH = 3;
  localparam int OW    = $clog2(DEPTH + 1);

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          Flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
`ifdef PIPELINE_REGISTER_OCC_EN
  logic [OW-1:0] occupancy;
`endif

  pipeline_register #(.DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Flush     (Flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef PIPELINE_REGISTER_OCC_EN
    ,
    .occupancy (occupancy)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  int edge_cnt = 0;
  always @(posedge Clk) edge_cnt++;

  // ---------------- scoreboard state ----------------
  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] exp_q[$];
  int            acc_q[$];
  bit            strict_q[$];
  bit            mon_en      = 1'b0;
  bit            strict_next = 1'b0;
  bit            gap_chk     = 1'b0;
  int            last_emit   = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    acc_q.delete();
    strict_q.delete();
  endtask

  // ---------------- driver ----------------
  // Called 1 time unit after a rising edge. It applies the inputs for one
  // cycle and returns 1 time unit after the next rising edge.
  task automatic step(input bit iv, input logic [DW-1:0] id, input bit ordy,
                      input bit fl, output bit fired);
    int ae;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    Flush     = fl;
    @(negedge Clk);
    fired = iv && (in_ready === 1'b1);
    ae    = edge_cnt + 1;
    @(posedge Clk);
    if (fl) begin
      clear_model();
    end else if (fired) begin
      exp_q.push_back(id);
      acc_q.push_back(ae);
      strict_q.push_back(strict_next);
    end
    #1;
  endtask

  task automatic idle(input bit ordy, input int n);
    bit f;
    for (int i = 0; i < n; i++) step(1'b0, '0, ordy, 1'b0, f);
  endtask

  // ---------------- monitor ----------------
  always @(negedge Clk) begin
    if (mon_en && Rst_n === 1'b1) begin
      int emit;
      int lat;
      logic [DW-1:0] w;
      check("in_ready", in_ready, !(exp_q.size() == DEPTH && out_ready === 1'b0));
`ifdef PIPELINE_REGISTER_OCC_EN
      check("occupancy", occupancy, exp_q.size());
`endif
      if (exp_q.size() == 0) begin
        check("out_valid_empty", out_valid, 1'b0);
      end else if (out_valid === 1'b1 && out_ready === 1'b1) begin
        emit = edge_cnt + 1;
        w    = exp_q.pop_front();
        lat  = emit - acc_q.pop_front();
        check("out_data", out_data, w);
        if (strict_q.pop_front()) check("latency_exact", lat, DEPTH);
        else                      check("latency_min", lat >= DEPTH, 1'b1);
        if (gap_chk && last_emit >= 0) check("no_gap", emit, last_emit + 1);
        last_emit = emit;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit f;
    int w;
    Rst_n = 1'b0; Flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, 8'h00);
    check("reset_in_ready", in_ready, 1'b1);
`ifdef PIPELINE_REGISTER_OCC_EN
    check("reset_occupancy", occupancy, 0);
`endif
    Rst_n  = 1'b1;
    mon_en = 1'b1;

    // Back-to-back stream with out_ready=1: exact latency, in_ready stays high.
    strict_next = 1'b1;
    step(1'b1, 8'h01, 1'b1, 1'b0, f); check("t1_accept_01", f, 1'b1);
    step(1'b1, 8'h02, 1'b1, 1'b0, f); check("t1_accept_02", f, 1'b1);
    step(1'b1, 8'h03, 1'b1, 1'b0, f); check("t1_accept_03", f, 1'b1);
    strict_next = 1'b0;
    idle(1'b1, 5);

    // Stalled output: three words fill the pipe, and the fourth waits upstream.
    w = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'hA1 + 8'(w), 1'b0, 1'b0, f);
      if (f) w++;
    end
    check("t2_accepted_while_stalled", w, 3);
    in_valid = 1'b1; in_data = 8'hA4; out_ready = 1'b0; #1;
    check("t2_in_ready_full", in_ready, 1'b0);
    gap_chk = 1'b1; last_emit = -1;
    for (int i = 0; i < 20 && !(w == 4 && exp_q.size() == 0); i++) begin
      if (w < 4) begin
        step(1'b1, 8'hA1 + 8'(w), 1'b1, 1'b0, f);
        if (f) w++;
      end else begin
        step(1'b0, '0, 1'b1, 1'b0, f);
      end
    end
    gap_chk = 1'b0;
    check("t2_all_accepted", w, 4);
    check("t2_drained", exp_q.size(), 0);

    // Full pipe with out_ready=1 takes a word on every edge.
    for (int i = 0; i < 3; i++) step(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0, f);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'hB3 + 8'(i), 1'b1, 1'b0, f);
      check("t3_full_passthrough", f, 1'b1);
    end
    idle(1'b1, 6);

    // Flush with two words held and an input word offered at the same time.
    step(1'b1, 8'hC1, 1'b0, 1'b0, f);
    step(1'b1, 8'hC2, 1'b0, 1'b0, f);
    step(1'b1, 8'hCC, 1'b0, 1'b1, f);
    check("t4_flush_out_valid", out_valid, 1'b0);
`ifdef PIPELINE_REGISTER_OCC_EN
    check("t4_flush_occupancy", occupancy, 0);
`endif
    idle(1'b1, 6);

    // Asynchronous reset between edges with three words held.
    for (int i = 0; i < 3; i++) step(1'b1, 8'hD1 + 8'(i), 1'b0, 1'b0, f);
    #2;
    Rst_n = 1'b0;
    clear_model();
    #1;
    check("t5_async_out_valid", out_valid, 1'b0);
    check("t5_async_out_data", out_data, 8'h00);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    strict_next = 1'b1;
    step(1'b1, 8'h55, 1'b1, 1'b0, f); check("t5_accept_55", f, 1'b1);
    strict_next = 1'b0;
    idle(1'b1, 5);

    // Bubble collapse: a later word still enters while the output is stalled.
    step(1'b1, 8'h7E, 1'b0, 1'b0, f); check("t6_accept_7e", f, 1'b1);
`ifdef PIPELINE_REGISTER_OCC_EN
    check("t6_occupancy_1", occupancy, 1);
`endif
    idle(1'b0, 1);
    step(1'b1, 8'h7F, 1'b0, 1'b0, f); check("t6_accept_7f", f, 1'b1);
`ifdef PIPELINE_REGISTER_OCC_EN
    check("t6_occupancy_2", occupancy, 2);
`endif
    idle(1'b1, 6);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, f);
    end
    idle(1'b1, 10);
    check("final_drained", exp_q.size(), 0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
